// File: rtl/eq_chain_engine.sv
// eq_chain_engine: time-multiplexed cascaded biquad equaliser, one shared MAC runs every band in turn.
// Defining EQ_BYPASS_EN adds a per-band bypass mask sampled with each accepted sample.
module eq_chain_engine #(
   parameter int DATA_W    = 16,
   parameter int NBANDS    = 6,
   parameter int COEF_W    = 18,
   parameter int Q_FP      = 15,
   parameter int GUARD     = 4,
   parameter int ACC_W     = 48,
   parameter int PRE_SHIFT = 2,
   localparam int INT_W    = DATA_W + GUARD,
   localparam int CB_W     = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   input  logic [2:0]        i_shift,
   input  logic              i_cfg_we,
   input  logic [CB_W-1:0]   i_cfg_band,
   input  logic [2:0]        i_cfg_idx,
   input  logic [COEF_W-1:0] i_cfg_coef,
   output logic              o_cfg_drop,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_sat
`ifdef EQ_BYPASS_EN
   ,
   input  logic [NBANDS-1:0] i_bypass_mask
`endif
);
   typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
   state_t                    state_q, state_d;
   logic [CB_W-1:0]           band_q, band_d, band_nx;
   logic [2:0]                tap_q, tap_d, sh_eff;
   logic signed [ACC_W-1:0]   acc_q, acc_d, prod, y_sh;
   logic signed [INT_W-1:0]   x_q, x_ext, x_in, opnd, y_sat, y_wb;
   logic signed [COEF_W-1:0]  coef;
   logic signed [COEF_W-1:0]  coef_q [NBANDS][5];
   logic signed [INT_W-1:0]   x1_q [NBANDS];
   logic signed [INT_W-1:0]   x2_q [NBANDS];
   logic signed [INT_W-1:0]   y1_q [NBANDS];
   logic signed [INT_W-1:0]   y2_q [NBANDS];
   logic [NBANDS-1:0]         byp_q, mask_in;
   logic [ACC_W-INT_W:0]      y_hi;
   logic [GUARD:0]            o_hi;
   logic [DATA_W-1:0]         o_data_q, out_sat;
   logic                      o_sat_q, drop_q, y_fit, out_fit, accept, last, band_ok, wr_ok;

   assign accept  = i_valid && state_q == IDLE;
   assign band_ok = 32'(i_cfg_band) < NBANDS;
   assign wr_ok   = i_cfg_we && state_q == IDLE && band_ok && i_cfg_idx < 3'd5;
   assign last    = band_q == CB_W'(NBANDS - 1);
   assign band_nx = band_q + 1'b1;
   assign sh_eff  = (i_shift > 3'd4) ? 3'd0 : i_shift;
   assign x_ext   = {{GUARD{i_data[DATA_W-1]}}, i_data};
   assign x_in    = x_ext >>> (PRE_SHIFT + 32'(sh_eff));

   // Shared MAC: one coefficient/operand pair per cycle, feedback terms subtracted.
   assign coef  = coef_q[band_q][tap_q];
   assign opnd  = (tap_q == 3'd0) ? x_q :
                  (tap_q == 3'd1) ? x1_q[band_q] :
                  (tap_q == 3'd2) ? x2_q[band_q] :
                  (tap_q == 3'd3) ? y1_q[band_q] : y2_q[band_q];
   assign prod  = ACC_W'(coef) * ACC_W'(opnd);
   assign acc_d = (tap_q == 3'd0) ? prod : (tap_q >= 3'd3) ? acc_q - prod : acc_q + prod;

   assign y_sh    = acc_q >>> Q_FP;
   assign y_hi    = y_sh[ACC_W-1:INT_W-1];
   assign y_fit   = &y_hi || ~|y_hi;
   assign y_sat   = y_fit ? y_sh[INT_W-1:0] : {y_sh[ACC_W-1], {(INT_W-1){~y_sh[ACC_W-1]}}};
   assign y_wb    = byp_q[band_q] ? x_q : y_sat;
   assign o_hi    = y_wb[INT_W-1:DATA_W-1];
   assign out_fit = &o_hi || ~|o_hi;
   assign out_sat = out_fit ? y_wb[DATA_W-1:0] : {y_wb[INT_W-1], {(DATA_W-1){~y_wb[INT_W-1]}}};

`ifdef EQ_BYPASS_EN
   assign mask_in = i_bypass_mask;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) byp_q <= '0;
      else if (accept) byp_q <= i_bypass_mask;
`else
   assign mask_in = '0;
   assign byp_q   = '0;
`endif

   always_comb begin
      state_d = state_q;
      band_d  = band_q;
      tap_d   = tap_q;
      case (state_q)
         IDLE: if (i_valid) begin
            state_d = mask_in[0] ? WB : MAC;
            band_d  = '0;
            tap_d   = '0;
         end
         MAC: begin
            tap_d   = tap_q + 3'd1;
            state_d = (tap_q == 3'd4) ? WB : MAC;
         end
         WB: if (last) state_d = DONE;
         else begin
            band_d  = band_nx;
            tap_d   = '0;
            state_d = byp_q[band_nx] ? WB : MAC;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state_q <= IDLE;
         band_q  <= '0;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         band_q  <= band_d;
         tap_q   <= tap_d;
      end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         acc_q    <= '0;
         x_q      <= '0;
         o_data_q <= '0;
         o_sat_q  <= 1'b0;
         drop_q   <= 1'b0;
         for (int b = 0; b < NBANDS; b++) begin
            x1_q[b] <= '0;
            x2_q[b] <= '0;
            y1_q[b] <= '0;
            y2_q[b] <= '0;
            for (int t = 0; t < 5; t++) coef_q[b][t] <= (t == 0) ? COEF_W'(1) << Q_FP : '0;
         end
      end else begin
         drop_q <= i_cfg_we && (state_q != IDLE || !band_ok);
         if (wr_ok) coef_q[i_cfg_band][i_cfg_idx] <= i_cfg_coef;
         if (accept) x_q <= x_in;
         if (state_q == MAC) acc_q <= acc_d;
         if (state_q == WB) begin
            x_q <= y_wb;
            if (!byp_q[band_q]) begin
               x2_q[band_q] <= x1_q[band_q];
               x1_q[band_q] <= x_q;
               y2_q[band_q] <= y1_q[band_q];
               y1_q[band_q] <= y_wb;
            end
            if (last) begin
               o_data_q <= out_sat;
               o_sat_q  <= !out_fit;
            end
         end
      end

   assign o_ready    = state_q == IDLE;
   assign o_valid    = state_q == DONE;
   assign o_data     = o_data_q;
   assign o_sat      = o_sat_q;
   assign o_cfg_drop = drop_q;
endmodule

// File: tb/tb_eq_chain_engine.sv
// tb_eq_chain_engine: randomized and directed checks of eq_chain_engine against an arithmetic model.
// Bypass scenarios are included when EQ_BYPASS_EN is defined.
module tb_eq_chain_engine;
   localparam int NB = 6;
   logic        clk = 0, rst = 1, valid = 0, cfg_we = 0;
   logic [15:0] data = 0;
   logic [2:0]  shift = 0, cfg_band = 0, cfg_idx = 0;
   logic [17:0] cfg_coef = 0;
   logic        ready, drop, ovalid, osat;
   logic [15:0] odata;
`ifdef EQ_BYPASS_EN
   logic [NB-1:0] bypass = 0;
`endif
   int errors = 0, checks = 0;
   longint mc [NB][5];
   longint mx1 [NB], mx2 [NB], my1 [NB], my2 [NB];

   eq_chain_engine dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(ready),
      .i_shift(shift), .i_cfg_we(cfg_we), .i_cfg_band(cfg_band), .i_cfg_idx(cfg_idx),
      .i_cfg_coef(cfg_coef), .o_cfg_drop(drop), .o_valid(ovalid),
`ifdef EQ_BYPASS_EN
      .i_bypass_mask(bypass),
`endif
      .o_data(odata), .o_sat(osat));

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int b = 0; b < NB; b++) begin
         for (int t = 0; t < 5; t++) mc[b][t] = (t == 0) ? 64'sd32768 : 64'sd0;
         mx1[b] = 0; mx2[b] = 0; my1[b] = 0; my2[b] = 0;
      end
   endfunction

   function automatic void model_write(input int b, input int i, input int c);
      if (b < NB && i < 5) mc[b][i] = longint'(c);
   endfunction

   function automatic void model_run(input logic [15:0] d, input int sh, input int mask,
                                     output logic [15:0] od, output logic os);
      longint x, acc, y;
      int s;
      s = (sh > 4) ? 0 : sh;
      x = longint'($signed(d)) >>> (2 + s);
      for (int b = 0; b < NB; b++) begin
         if (!mask[b]) begin
            acc = mc[b][0]*x + mc[b][1]*mx1[b] + mc[b][2]*mx2[b] - mc[b][3]*my1[b] - mc[b][4]*my2[b];
            y = acc >>> 15;
            if (y > 524287) y = 524287;
            if (y < -524288) y = -524288;
            mx2[b] = mx1[b]; mx1[b] = x; my2[b] = my1[b]; my1[b] = y;
            x = y;
         end
      end
      os = (x > 32767) || (x < -32768);
      od = (x > 32767) ? 16'h7fff : (x < -32768) ? 16'h8000 : 16'(x);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1; valid = 0; cfg_we = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!ready) begin errors++; $display("FAIL ready_timeout: o_ready=%b required 1", ready); end
   endtask

   task automatic cfg_write(input int b, input int i, input int c);
      wait_ready();
      cfg_we = 1; cfg_band = 3'(b); cfg_idx = 3'(i); cfg_coef = 18'(c);
      @(negedge clk);
      cfg_we = 0;
      checks++;
      if (drop !== (b >= NB)) begin
         errors++; $display("FAIL cfg_drop band=%0d idx=%0d: got %b required %b", b, i, drop, b >= NB);
      end
      model_write(b, i, c);
   endtask

   task automatic run_sample(input logic [15:0] d, input int sh, input int mask, input bit wr,
                             input int wb, input int wi, input int wc, input string nm);
      logic [15:0] ed;
      logic        es;
      int n, lat;
      lat = 1;
      for (int b = 0; b < NB; b++) lat += mask[b] ? 1 : 6;
      wait_ready();
      if (wr) model_write(wb, wi, wc);
      model_run(d, sh, mask, ed, es);
      valid = 1; data = d; shift = 3'(sh);
`ifdef EQ_BYPASS_EN
      bypass = NB'(mask);
`endif
      cfg_we = wr; cfg_band = 3'(wb); cfg_idx = 3'(wi); cfg_coef = 18'(wc);
      @(negedge clk);
      valid = 0; cfg_we = 0; n = 1;
      if (wr) begin
         checks++;
         if (drop !== (wb >= NB)) begin errors++; $display("FAIL %s drop: got %b required %b", nm, drop, wb >= NB); end
      end
      while (!ovalid && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", nm, n, lat); end
      if (!ovalid) return;
      checks++;
      if (odata !== ed) begin errors++; $display("FAIL %s data: got %h required %h", nm, odata, ed); end
      checks++;
      if (osat !== es) begin errors++; $display("FAIL %s sat: got %b required %b", nm, osat, es); end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || ovalid !== 1'b0) begin
         errors++; $display("FAIL %s after: ready=%b valid=%b required 1/0", nm, ready, ovalid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ready, ovalid, osat, drop, odata} !== {4'b1000, 16'h0000}) begin
         errors++; $display("FAIL reset_state: got r%b v%b s%b d%b %h required r1 v0 s0 d0 0000",
                            ready, ovalid, osat, drop, odata);
      end
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "passthru");
      checks++;
      if (odata !== 16'h0400) begin errors++; $display("FAIL passthru_hold: got %h required 0400", odata); end
   endtask

   task automatic test_delay_tap();
      do_reset();
      cfg_write(0, 0, 0);
      cfg_write(0, 1, 32768);
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "delay_first");
      run_sample(16'h0000, 0, 0, 0, 0, 0, 0, "delay_second");
   endtask

   task automatic test_saturation();
      do_reset();
      for (int b = 0; b < 3; b++) cfg_write(b, 0, 131071);
      run_sample(16'h7fff, 0, 0, 0, 0, 0, 0, "sat_pos");
      run_sample(16'h8000, 0, 0, 0, 0, 0, 0, "sat_neg");
   endtask

   task automatic test_cfg_rules();
      do_reset();
      cfg_write(6, 0, 0);
      cfg_write(7, 0, 0);
      cfg_write(0, 5, 0);
      cfg_write(2, 7, 12345);
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "cfg_ignored");
      run_sample(16'h1000, 0, 0, 1, 0, 0, 16384, "cfg_same_cycle");
      run_sample(16'hf000, 3, 0, 0, 0, 0, 0, "shift3");
      run_sample(16'h4000, 6, 0, 0, 0, 0, 0, "shift6");
   endtask

   task automatic test_busy();
      logic [15:0] ed;
      logic        es;
      int n, pulses = 0;
      do_reset();
      wait_ready();
      model_run(16'h1000, 0, 0, ed, es);
      valid = 1; data = 16'h1000; shift = 0;
      @(negedge clk);
      valid = 0; n = 1;
      repeat (4) begin @(negedge clk); n++; end
      valid = 1; data = 16'h7fff; cfg_we = 1; cfg_band = 0; cfg_idx = 0; cfg_coef = 0;
      @(negedge clk);
      n++; valid = 0; cfg_we = 0;
      checks++;
      if (drop !== 1'b1) begin errors++; $display("FAIL busy_drop: got %b required 1", drop); end
      while (n < 120) begin
         if (ovalid) begin
            pulses++;
            checks++;
            if (n != 37 || odata !== ed) begin
               errors++; $display("FAIL busy_out: cycle %0d data %h required 37 %h", n, odata, ed);
            end
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL busy_pulses: got %0d required 1", pulses); end
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "busy_rerun");
   endtask

   task automatic test_reset_midop();
      int seen = 0;
      do_reset();
      cfg_write(0, 1, 32768);
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "midop_prime");
      cfg_write(0, 0, 16384);
      wait_ready();
      valid = 1; data = 16'h1000;
      @(negedge clk);
      valid = 0;
      repeat (9) @(negedge clk);
      rst = 1;
      repeat (2) begin @(negedge clk); if (ovalid) seen++; end
      rst = 0;
      model_reset();
      checks++;
      if (ready !== 1'b1 || odata !== 16'h0 || osat !== 1'b0) begin
         errors++; $display("FAIL midop_state: r%b %h s%b required r1 0000 s0", ready, odata, osat);
      end
      repeat (60) begin @(negedge clk); if (ovalid) seen++; end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL midop_valid: got %0d pulses required 0", seen); end
      cfg_write(0, 1, 32768);
      run_sample(16'h0000, 0, 0, 0, 0, 0, 0, "midop_history");
      run_sample(16'h1000, 0, 0, 0, 0, 0, 0, "midop_coef");
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 1)
            cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65536)) - 32768);
         run_sample(16'($urandom), int'($urandom_range(0, 7)), 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 65536)) - 32768, "random");
      end
   endtask

`ifdef EQ_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      cfg_write(0, 0, 0);
      run_sample(16'h1000, 0, 1, 0, 0, 0, 0, "bypass_band0");
      for (int k = 0; k < 8; k++)
         run_sample(16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 63)), 0, 0, 0, 0, "bypass_rand");
   endtask
`endif

   initial begin
      test_reset();
      test_delay_tap();
      test_saturation();
      test_cfg_rules();
      test_busy();
      test_reset_midop();
      test_random();
`ifdef EQ_BYPASS_EN
      test_bypass();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
